// File: rtl/sm4_sched_pkg.sv
// rtl/sm4_sched_pkg.sv - shared types and constants for the SM4 channel scheduler
package sm4_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_KEYLD = 3'd3,
        ST_KWAIT = 3'd4,
        ST_XFER  = 3'd5
    } sched_state_e;

    // Width of the engine tuser field that carries the channel index.
    localparam int TUSER_W      = 8;

    // Cycles the engine needs for key expansion after a key-load strobe.
    localparam int KEY_WAIT_DEF = 40;

    // Width of the key-wait counter; bounds the largest usable KEY_WAIT.
    localparam int KCNT_W       = 16;

endpackage

// File: rtl/sm4_rr_arb.sv
// rtl/sm4_rr_arb.sv - combinational round-robin arbiter, search starts after ptr
module sm4_rr_arb #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt_oh,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_vld
);

    logic [CH_W-1:0] idx_w;
    int              idx;

    // Scan ptr+1, ptr+2, ... ptr+NUM_CH (wrapping); first requester wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_w = CH_W'(idx);
            if (!gnt_vld && req[idx_w]) begin
                gnt_vld        = 1'b1;
                gnt_idx        = idx_w;
                gnt_oh[idx_w]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm4_axis8_chan_sched.sv
// rtl/sm4_axis8_chan_sched.sv - time-shares one SM4 byte-stream engine between channels
module sm4_axis8_chan_sched
    import sm4_sched_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int KEY_WAIT = KEY_WAIT_DEF,
    parameter int OUT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH*128-1:0] ch_key,
    input  logic [NUM_CH-1:0]     ch_sel,
    input  logic [NUM_CH-1:0]     ch_key_upd,
    input  logic [NUM_CH*8-1:0]   s_axis_tdata,
    input  logic [NUM_CH-1:0]     s_axis_tvalid,
    input  logic [NUM_CH-1:0]     s_axis_tlast,
    output logic [NUM_CH-1:0]     s_axis_tready,
    output logic                  e_sm4_vld,
    output logic [127:0]          e_sm4_key,
    output logic                  e_sm4_sel,
    output logic [7:0]            e_s_axis_tdata,
    output logic                  e_s_axis_tvalid,
    output logic                  e_s_axis_tlast,
    output logic [TUSER_W-1:0]    e_s_axis_tuser,
    input  logic                  e_s_axis_tready,
    input  logic [7:0]            e_m_axis_tdata,
    input  logic                  e_m_axis_tvalid,
    input  logic                  e_m_axis_tlast,
    input  logic [TUSER_W-1:0]    e_m_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [CH_W-1:0]       m_axis_tdest
);

    sched_state_e      state_q, state_d;
    logic [CH_W-1:0]   g_q, g_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   ld_ch_q, ld_ch_d;
    logic              ld_valid_q, ld_valid_d;
    logic [NUM_CH-1:0] dirty_q, dirty_d;
    logic [OUT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [KCNT_W-1:0] kcnt_q, kcnt_d;
    logic              e_sm4_vld_q, e_sm4_vld_d;
    logic [127:0]      key_q, key_d;
    logic              sel_q, sel_d;

    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   gnt_idx;
    logic              gnt_vld;

    logic [7:0]        g_tdata;
    logic              g_tvalid;
    logic              g_tlast;
    logic              xfer;
    logic              out_full;
    logic              stall;
    logic              hs_last;
    logic              out_dec;
    logic              unused_bits;

    sm4_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (s_axis_tvalid),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // Granted-channel input mux and engine-side stream; the tlast beat is
    // held off while the outstanding-packet counter is saturated.
    always_comb begin
        g_tdata  = s_axis_tdata[{g_q, 3'b000} +: 8];
        g_tvalid = s_axis_tvalid[g_q];
        g_tlast  = s_axis_tlast[g_q];
        xfer     = (state_q == ST_XFER);
        out_full = &out_cnt_q;
        stall    = g_tlast && out_full;

        e_s_axis_tdata  = g_tdata;
        e_s_axis_tvalid = xfer && g_tvalid && !stall;
        e_s_axis_tlast  = xfer && g_tlast;
        e_s_axis_tuser  = TUSER_W'(g_q);

        s_axis_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s_axis_tready[i] = xfer && (g_q == CH_W'(i)) && e_s_axis_tready && !stall;
        end

        hs_last = e_s_axis_tvalid && e_s_axis_tready && g_tlast;
        out_dec = e_m_axis_tvalid && e_m_axis_tlast;
    end

    // Scheduler next-state: arbitration, drain, key load, key wait, transfer.
    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        ld_ch_d     = ld_ch_q;
        ld_valid_d  = ld_valid_q;
        dirty_d     = dirty_q;
        out_cnt_d   = out_cnt_q;
        kcnt_d      = kcnt_q;
        e_sm4_vld_d = 1'b0;
        key_d       = key_q;
        sel_d       = sel_q;

        if (hs_last && !out_dec && !out_full) begin
            out_cnt_d = out_cnt_q + OUT_W'(1);
        end else if (out_dec && !hs_last && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - OUT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (|s_axis_tvalid) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (gnt_vld) begin
                    g_d = gnt_idx;
                    if (ld_valid_q && (ld_ch_q == gnt_idx) && !dirty_q[gnt_idx]) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Engine must be empty before its key changes under it.
                if (out_cnt_q == '0) begin
                    state_d     = ST_KEYLD;
                    e_sm4_vld_d = 1'b1;
                    key_d       = ch_key[{g_q, 7'b0000000} +: 128];
                    sel_d       = ch_sel[g_q];
                end
            end
            ST_KEYLD: begin
                ld_ch_d       = g_q;
                ld_valid_d    = 1'b1;
                dirty_d[g_q]  = 1'b0;
                kcnt_d        = '0;
                state_d       = ST_KWAIT;
            end
            ST_KWAIT: begin
                if (kcnt_q == KCNT_W'(KEY_WAIT - 1)) begin
                    state_d = ST_XFER;
                end else begin
                    kcnt_d = kcnt_q + KCNT_W'(1);
                end
            end
            ST_XFER: begin
                if (hs_last) begin
                    ptr_d   = g_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh update always survives a same-cycle clear from KEYLD.
        dirty_d = dirty_d | ch_key_upd;
    end

    // All scheduler state, asynchronously cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            g_q         <= '0;
            ptr_q       <= '0;
            ld_ch_q     <= '0;
            ld_valid_q  <= 1'b0;
            dirty_q     <= '0;
            out_cnt_q   <= '0;
            kcnt_q      <= '0;
            e_sm4_vld_q <= 1'b0;
            key_q       <= '0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            ptr_q       <= ptr_d;
            ld_ch_q     <= ld_ch_d;
            ld_valid_q  <= ld_valid_d;
            dirty_q     <= dirty_d;
            out_cnt_q   <= out_cnt_d;
            kcnt_q      <= kcnt_d;
            e_sm4_vld_q <= e_sm4_vld_d;
            key_q       <= key_d;
            sel_q       <= sel_d;
        end
    end

    assign e_sm4_vld     = e_sm4_vld_q;
    assign e_sm4_key     = key_q;
    assign e_sm4_sel     = sel_q;

    assign m_axis_tdata  = e_m_axis_tdata;
    assign m_axis_tvalid = e_m_axis_tvalid;
    assign m_axis_tlast  = e_m_axis_tlast;
    assign m_axis_tdest  = e_m_axis_tuser[CH_W-1:0];

    assign unused_bits   = ^{e_m_axis_tuser[TUSER_W-1:CH_W], gnt_oh};

endmodule

// File: tb/tb_sm4_axis8_chan_sched.sv
// tb/tb_sm4_axis8_chan_sched.sv - scoreboard bench for the SM4 channel scheduler
module tb_sm4_axis8_chan_sched;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int KEY_WAIT = 40;
    localparam int OUT_W    = 4;

    localparam logic [127:0] K0  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] K1  = 128'h1111222233334444555566667777a5a5;
    localparam logic [127:0] K2  = 128'h2222333344445555666677778888003c;
    localparam logic [127:0] K3  = 128'h33334444555566667777888899990f0f;
    localparam logic [127:0] K2B = 128'hdeadbeefcafef00d0badc0de1234c3c3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_CH*128-1:0] ch_key;
    logic [NUM_CH-1:0]     ch_sel;
    logic [NUM_CH-1:0]     ch_key_upd;
    logic [NUM_CH*8-1:0]   s_tdata;
    logic [NUM_CH-1:0]     s_tvalid;
    logic [NUM_CH-1:0]     s_tlast;
    logic [NUM_CH-1:0]     s_tready;
    logic                  e_sm4_vld;
    logic [127:0]          e_sm4_key;
    logic                  e_sm4_sel;
    logic [7:0]            e_s_tdata;
    logic                  e_s_tvalid;
    logic                  e_s_tlast;
    logic [7:0]            e_s_tuser;
    logic                  e_s_tready;
    logic [7:0]            e_m_tdata;
    logic                  e_m_tvalid;
    logic                  e_m_tlast;
    logic [7:0]            e_m_tuser;
    logic [7:0]            m_tdata;
    logic                  m_tvalid;
    logic                  m_tlast;
    logic [CH_W-1:0]       m_tdest;

    logic [7:0] drv_data  [NUM_CH];
    logic       drv_valid [NUM_CH];
    logic       drv_last  [NUM_CH];

    sm4_axis8_chan_sched #(
        .NUM_CH (NUM_CH), .CH_W (CH_W), .KEY_WAIT (KEY_WAIT), .OUT_W (OUT_W)
    ) dut (
        .clk (clk), .rst (rst),
        .ch_key (ch_key), .ch_sel (ch_sel), .ch_key_upd (ch_key_upd),
        .s_axis_tdata (s_tdata), .s_axis_tvalid (s_tvalid),
        .s_axis_tlast (s_tlast), .s_axis_tready (s_tready),
        .e_sm4_vld (e_sm4_vld), .e_sm4_key (e_sm4_key), .e_sm4_sel (e_sm4_sel),
        .e_s_axis_tdata (e_s_tdata), .e_s_axis_tvalid (e_s_tvalid),
        .e_s_axis_tlast (e_s_tlast), .e_s_axis_tuser (e_s_tuser),
        .e_s_axis_tready (e_s_tready),
        .e_m_axis_tdata (e_m_tdata), .e_m_axis_tvalid (e_m_tvalid),
        .e_m_axis_tlast (e_m_tlast), .e_m_axis_tuser (e_m_tuser),
        .m_axis_tdata (m_tdata), .m_axis_tvalid (m_tvalid),
        .m_axis_tlast (m_tlast), .m_axis_tdest (m_tdest)
    );

    always_comb begin
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s_tdata[8*i +: 8] = drv_data[i];
            s_tvalid[i]       = drv_valid[i];
            s_tlast[i]        = drv_last[i];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] key_mask(input logic [127:0] k, input logic s);
        return k[7:0] ^ (s ? 8'hff : 8'h00);
    endfunction

    // Scoreboard of expected result bytes: {data, last, dest}
    logic [10:0]  sb_q [$];
    logic [128:0] keyq [$];

    task automatic push_expect(input int ch, input int len, input logic [7:0] base,
                               input logic [127:0] k, input logic s);
        int n_out;
        logic [7:0] d;
        n_out = ((len + 15) / 16) * 16;
        for (int i = 0; i < n_out; i++) begin
            d = (i < len) ? (base + 8'(i)) : 8'h00;
            sb_q.push_back({d ^ key_mask(k, s), (i == n_out - 1), CH_W'(ch)});
        end
    endtask

    // Engine model: XOR with loaded key byte, pad to 16-byte blocks
    logic [7:0] eng_buf [$];
    logic [16:0] eng_q  [$];
    logic [7:0] eng_mask = 8'h00;

    initial begin
        logic [16:0] o;
        e_m_tdata  = '0;
        e_m_tvalid = 1'b0;
        e_m_tlast  = 1'b0;
        e_m_tuser  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                eng_buf.delete();
                eng_q.delete();
                eng_mask = 8'h00;
            end else begin
                if (e_sm4_vld) eng_mask = key_mask(e_sm4_key, e_sm4_sel);
                if (e_s_tvalid && e_s_tready) begin
                    eng_buf.push_back(e_s_tdata ^ eng_mask);
                    if (e_s_tlast) begin
                        while ((eng_buf.size() % 16) != 0) eng_buf.push_back(eng_mask);
                        for (int i = 0; i < eng_buf.size(); i++)
                            eng_q.push_back({e_s_tuser, (i == eng_buf.size() - 1), eng_buf[i]});
                        eng_buf.delete();
                    end
                end
            end
            @(posedge clk);
            #1;
            if (rst || eng_q.size() == 0) begin
                e_m_tvalid = 1'b0;
                e_m_tlast  = 1'b0;
            end else begin
                o = eng_q.pop_front();
                e_m_tdata  = o[7:0];
                e_m_tlast  = o[8];
                e_m_tuser  = o[16:9];
                e_m_tvalid = 1'b1;
            end
        end
    end

    // Monitor: result bytes, key loads, drain-before-load and key-wait spacing
    int vld_cnt   = 0;
    int since_vld = 0;
    bit armed     = 1'b0;

    initial begin
        logic [10:0]  e;
        logic [128:0] ek;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (m_tvalid) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_out", {m_tdata, m_tlast, m_tdest}, 11'h0);
                    end else begin
                        e = sb_q.pop_front();
                        check("out_byte", {m_tdata, m_tlast, m_tdest}, e);
                    end
                end
                if (e_sm4_vld) begin
                    vld_cnt++;
                    ek = (keyq.size() != 0) ? keyq.pop_front() : 129'h0;
                    check("key_load", {e_sm4_sel, e_sm4_key}, ek);
                    check("drain_before_load",
                          (eng_q.size() != 0) || (eng_buf.size() != 0) || e_m_tvalid, 1'b0);
                    since_vld = 0;
                    armed     = 1'b1;
                end else begin
                    since_vld++;
                end
                if (armed && e_s_tvalid && e_s_tready) begin
                    check("key_wait_held", since_vld > KEY_WAIT, 1'b1);
                    armed = 1'b0;
                end
            end
        end
    end

    task automatic send_pkt(input int ch, input int len, input logic [7:0] base,
                            input int upd_at, input logic [127:0] new_key);
        bit done;
        bit all_done;
        all_done = 1'b1;
        for (int i = 0; i < len; i++) begin
            drv_data[ch]  = base + 8'(i);
            drv_last[ch]  = (i == len - 1);
            drv_valid[ch] = 1'b1;
            if (i == upd_at) begin
                ch_key[128*ch +: 128] = new_key;
                ch_key_upd[ch]        = 1'b1;
            end
            done = 1'b0;
            for (int t = 0; t < 3000 && !done; t++) begin
                @(negedge clk);
                done = s_tready[ch] && !rst;
                @(posedge clk);
                #1;
                ch_key_upd[ch] = 1'b0;
            end
            if (!done) all_done = 1'b0;
        end
        drv_valid[ch] = 1'b0;
        drv_last[ch]  = 1'b0;
        check("pkt_accepted", all_done, 1'b1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 3000 && !idle; t++) begin
            @(negedge clk);
            idle = (sb_q.size() == 0) && (eng_q.size() == 0) && !e_m_tvalid;
        end
        check("drained", idle, 1'b1);
    endtask

    initial begin
        int v0;
        ch_key     = {K3, K2, K1, K0};
        ch_sel     = 4'b0010;
        ch_key_upd = '0;
        e_s_tready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            drv_data[i]  = '0;
            drv_valid[i] = 1'b0;
            drv_last[i]  = 1'b0;
        end

        repeat (3) @(negedge clk);
        check("rst_tready", s_tready, 4'h0);
        check("rst_vld", e_sm4_vld, 1'b0);
        check("rst_key", {e_sm4_sel, e_sm4_key}, 129'h0);
        check("rst_e_tvalid", e_s_tvalid, 1'b0);
        rst = 1'b0;

        // 1: single 16-byte packet on ch0
        keyq.push_back({1'b0, K0});
        push_expect(0, 16, 8'h00, K0, 1'b0);
        v0 = vld_cnt;
        send_pkt(0, 16, 8'h00, -1, '0);
        wait_idle();
        check("t1_loads", vld_cnt - v0, 1);

        // 2: ch1 and ch2 together, ch1 first
        keyq.push_back({1'b1, K1});
        keyq.push_back({1'b0, K2});
        push_expect(1, 16, 8'h40, K1, 1'b1);
        push_expect(2, 16, 8'h80, K2, 1'b0);
        v0 = vld_cnt;
        fork
            send_pkt(1, 16, 8'h40, -1, '0);
            send_pkt(2, 16, 8'h80, -1, '0);
        join
        wait_idle();
        check("t2_loads", vld_cnt - v0, 2);

        // 3: three back-to-back ch3 packets, one key load
        keyq.push_back({1'b0, K3});
        push_expect(3, 16, 8'h10, K3, 1'b0);
        push_expect(3, 5,  8'h20, K3, 1'b0);
        push_expect(3, 16, 8'h30, K3, 1'b0);
        v0 = vld_cnt;
        send_pkt(3, 16, 8'h10, -1, '0);
        send_pkt(3, 5,  8'h20, -1, '0);
        send_pkt(3, 16, 8'h30, -1, '0);
        wait_idle();
        check("t3_loads", vld_cnt - v0, 1);

        // 4: ch0 20-byte packet padded to 32
        keyq.push_back({1'b0, K0});
        push_expect(0, 20, 8'hc0, K0, 1'b0);
        v0 = vld_cnt;
        send_pkt(0, 20, 8'hc0, -1, '0);
        wait_idle();
        check("t4_loads", vld_cnt - v0, 1);

        // 5: key update mid-packet on ch2
        keyq.push_back({1'b0, K2});
        keyq.push_back({1'b0, K2B});
        push_expect(2, 16, 8'h60, K2,  1'b0);
        push_expect(2, 16, 8'h70, K2B, 1'b0);
        v0 = vld_cnt;
        send_pkt(2, 16, 8'h60, 5, K2B);
        send_pkt(2, 16, 8'h70, -1, '0);
        wait_idle();
        check("t5_loads", vld_cnt - v0, 2);

        // 6: reset during key wait, then the same grant reloads
        keyq.push_back({1'b1, K1});
        keyq.push_back({1'b1, K1});
        push_expect(1, 16, 8'h90, K1, 1'b1);
        v0 = vld_cnt;
        fork
            send_pkt(1, 16, 8'h90, -1, '0);
            begin
                bit seen;
                seen = 1'b0;
                for (int t = 0; t < 500 && !seen; t++) begin
                    @(negedge clk);
                    seen = e_sm4_vld;
                end
                check("t6_first_load", seen, 1'b1);
                repeat (5) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("t6_rst_tready", s_tready, 4'h0);
                check("t6_rst_vld", e_sm4_vld, 1'b0);
                check("t6_rst_e_tvalid", e_s_tvalid, 1'b0);
                rst = 1'b0;
            end
        join
        wait_idle();
        check("t6_loads", vld_cnt - v0, 2);

        check("sb_empty", sb_q.size(), 0);
        check("keyq_empty", keyq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
